// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Requester ids, FSM states and the wait counter width live here.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      READ,
      WAIT
   } state_e;

   localparam int REQ_FETCH   = 0;
   localparam int REQ_LOAD    = 1;
   localparam int REQ_STORE   = 2;
   localparam int DEF_NUM_REQ = 3;

   // Wide enough for READ_LAT up to 4.
   localparam int CNT_W = 3;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches from last+1 upward,
// wrapping, and returns a one-hot grant plus its index.
module rr_pick #(
   parameter int NUM_REQ = 3,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_last,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IDX_W-1:0]   o_idx
);

   int   w_pos;
   logic w_found;

   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_pos   = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_pos = (int'(i_last) + k) % NUM_REQ;
         if (!w_found && i_req[w_pos]) begin
            o_grant[w_pos] = 1'b1;
            o_idx          = IDX_W'(w_pos);
            w_found        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serializes fetch/load/store accesses onto the single data-memory
// port with round-robin fairness and returns one-hot completions.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 16,
   parameter int NUM_REQ  = DEF_NUM_REQ,
   parameter int READ_LAT = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      mem_re,
   output logic                      mem_we,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   input  logic [DATA_W-1:0]         mem_rdata
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_e             r_state;
   state_e             w_next;
   logic [IW-1:0]      r_last;
   logic [IW-1:0]      r_id;
   logic [IW-1:0]      w_idx;
   logic [NUM_REQ-1:0] w_grant;
   logic [NUM_REQ-1:0] w_id_oh;
   logic [ADDR_W-1:0]  r_addr;
   logic [DATA_W-1:0]  r_wdata;
   logic [DATA_W-1:0]  r_rsp_data;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_rd_done;
   logic               w_idle;
   logic               w_hs;
   logic               w_last_wait;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IW)
   ) u_pick (
      .i_req   (req_valid),
      .i_last  (r_last),
      .o_grant (w_grant),
      .o_idx   (w_idx)
   );

   assign w_idle      = (r_state == IDLE);
   assign w_hs        = w_idle & (|req_valid);
   assign w_last_wait = (r_state == WAIT) && (r_cnt == CNT_W'(1));
   assign w_id_oh     = NUM_REQ'(1) << r_id;

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (w_hs) w_next = req_we[w_idx] ? WRITE : READ;
         WRITE:   w_next = IDLE;
         READ:    w_next = WAIT;
         WAIT:    if (r_cnt == CNT_W'(1)) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last     <= IW'(NUM_REQ - 1);
         r_id       <= '0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_cnt      <= '0;
         r_rsp_data <= '0;
         r_rd_done  <= 1'b0;
      end else begin
         if (w_hs) begin
            r_id    <= w_idx;
            r_last  <= w_idx;
            r_addr  <= req_addr[w_idx*ADDR_W +: ADDR_W];
            r_wdata <= req_wdata[w_idx*DATA_W +: DATA_W];
         end
         if (r_state == READ)      r_cnt <= CNT_W'(READ_LAT);
         else if (r_state == WAIT) r_cnt <= r_cnt - CNT_W'(1);
         if (w_last_wait) r_rsp_data <= mem_rdata;
         // Read completion pulses in the IDLE cycle after the last wait.
         r_rd_done <= w_last_wait;
      end
   end

   assign req_ready = w_idle ? w_grant : '0;
   assign rsp_valid = ((r_state == WRITE) || r_rd_done) ? w_id_oh : '0;
   assign rsp_data  = r_rsp_data;
   assign mem_re    = (r_state == READ);
   assign mem_we    = (r_state == WRITE);
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;

endmodule
